// File: rtl/requests.sv
// Request/result structures shared by the MMU, the data cache and main memory.
package requests;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic        isWrite;
    logic        isPrivileged;
    logic        isValid;
  } cpuMemRequest_t;

  typedef struct packed {
    logic [63:0] data;
    logic        isValid;
  } cpuMemResult_t;

endpackage

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate cache of 64-bit words between
// the MMU physical port and main memory. Unaligned accesses bypass the array.
module data_cache
  import requests::*;
#(
  parameter int Lines = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  cpuMemRequest_t cpu_request,
  output cpuMemResult_t  cpu_result,
  input  logic           flush,
  output cpuMemRequest_t mem_request,
  input  cpuMemResult_t  mem_result
);

  localparam int IDX  = $clog2(Lines);
  localparam int TAGW = 64 - 3 - IDX;

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, DONE} state_t;

  state_t         state_reg, state_next;
  cpuMemResult_t  result_reg, result_next;
  cpuMemRequest_t mem_req_reg, mem_req_next;
  logic           flush_pending_reg, flush_pending_next;
  logic [63:0]    addr_reg, data_reg;

  logic [Lines-1:0] valid_reg, valid_next;
  logic [TAGW-1:0]  tag_mem  [Lines];
  logic [63:0]      line_mem [Lines];

  logic        latch;
  logic        fill;
  logic        clear_all;
  logic [63:0] fill_data;

  logic [IDX-1:0]  req_idx, line_idx;
  logic [TAGW-1:0] req_tag, line_tag;
  logic            req_hit, line_cacheable;

  assign req_idx  = cpu_request.addr[3 +: IDX];
  assign req_tag  = cpu_request.addr[63:3+IDX];
  assign req_hit  = (cpu_request.addr[2:0] == 3'b000) && valid_reg[req_idx] &&
                    (tag_mem[req_idx] == req_tag);

  assign line_idx       = addr_reg[3 +: IDX];
  assign line_tag       = addr_reg[63:3+IDX];
  assign line_cacheable = (addr_reg[2:0] == 3'b000);

  assign cpu_result  = result_reg;
  assign mem_request = mem_req_reg;

  always_comb begin
    state_next         = state_reg;
    result_next        = result_reg;
    mem_req_next       = mem_req_reg;
    flush_pending_next = flush_pending_reg;
    latch              = 1'b0;
    fill               = 1'b0;
    fill_data          = 64'd0;
    clear_all          = 1'b0;

    case (state_reg)
      IDLE: begin
        result_next = '0;
        if (flush) begin
          clear_all = 1'b1;
        end else if (cpu_request.isValid) begin
          latch = 1'b1;
          if (cpu_request.isWrite) begin
            mem_req_next = '{addr: cpu_request.addr, data: cpu_request.data, isWrite: 1'b1,
                             isPrivileged: cpu_request.isPrivileged, isValid: 1'b1};
            state_next   = MEM_WR;
          end else if (req_hit) begin
            result_next = '{data: line_mem[req_idx], isValid: 1'b1};
            state_next  = DONE;
          end else begin
            mem_req_next = '{addr: cpu_request.addr, data: 64'd0, isWrite: 1'b0,
                             isPrivileged: cpu_request.isPrivileged, isValid: 1'b1};
            state_next   = MEM_RD;
          end
        end
      end

      MEM_RD: begin
        if (flush) flush_pending_next = 1'b1;
        if (mem_result.isValid) begin
          fill         = line_cacheable;
          fill_data    = mem_result.data;
          result_next  = '{data: mem_result.data, isValid: 1'b1};
          mem_req_next = '0;
          state_next   = DONE;
        end
      end

      MEM_WR: begin
        if (flush) flush_pending_next = 1'b1;
        if (mem_result.isValid) begin
          fill         = line_cacheable;
          fill_data    = data_reg;
          result_next  = '{data: 64'd0, isValid: 1'b1};
          mem_req_next = '0;
          state_next   = DONE;
        end
      end

      DONE: begin
        // A flush seen during the transaction also drops the line just filled.
        clear_all          = flush_pending_reg | flush;
        flush_pending_next = 1'b0;
        result_next        = '0;
        mem_req_next       = '0;
        state_next         = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < Lines; gi++) begin : g_valid
    assign valid_next[gi] = clear_all ? 1'b0 :
                            (fill && (line_idx == IDX'(gi))) ? 1'b1 : valid_reg[gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      result_reg        <= '0;
      mem_req_reg       <= '0;
      flush_pending_reg <= 1'b0;
      valid_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      result_reg        <= result_next;
      mem_req_reg       <= mem_req_next;
      flush_pending_reg <= flush_pending_next;
      valid_reg         <= valid_next;
    end
  end

  // Tag/data storage carries no reset: the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (latch) begin
      addr_reg <= cpu_request.addr;
      data_reg <= cpu_request.data;
    end
    if (fill) begin
      tag_mem[line_idx]  <= line_tag;
      line_mem[line_idx] <= fill_data;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a behavioural memory plus a line-presence
// model decide hit/miss, returned data and memory traffic for every request.
module tb_data_cache;
  import requests::*;

  localparam int LINES = 16;

  logic           clock;
  logic           reset;
  logic           flush;
  cpuMemRequest_t cpu_request;
  cpuMemResult_t  cpu_result;
  cpuMemRequest_t mem_request;
  cpuMemResult_t  mem_result;

  data_cache #(.Lines(LINES)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_request(cpu_request),
    .cpu_result (cpu_result),
    .flush      (flush),
    .mem_request(mem_request),
    .mem_result (mem_result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks_total = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Main memory: word per exact address, with a deterministic default pattern.
  logic [63:0] mem_words [logic [63:0]];
  bit          mem_enable = 1'b1;
  int          mem_accesses = 0;
  int          wait_cnt = 0;
  logic [63:0] last_addr, last_data;
  logic        last_write, last_priv;

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return {a[31:0] ^ 32'h5a5a_1234, ~a[31:0]};
  endfunction

  always @(negedge clock) begin
    if (mem_result.isValid) begin
      mem_result = '0;
    end else if (mem_enable && mem_request.isValid) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        mem_accesses++;
        last_addr  = mem_request.addr;
        last_data  = mem_request.data;
        last_write = mem_request.isWrite;
        last_priv  = mem_request.isPrivileged;
        if (mem_request.isWrite) begin
          mem_words[mem_request.addr] = mem_request.data;
          mem_result = '{data: 64'd0, isValid: 1'b1};
        end else begin
          mem_result = '{data: mem_val(mem_request.addr), isValid: 1'b1};
        end
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  // Which aligned address each line currently holds.
  bit          model_valid [LINES];
  logic [63:0] model_addr  [LINES];

  function automatic void model_invalidate();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
  endfunction

  task automatic do_req(input logic [63:0] a, input logic [63:0] d, input bit w,
                        input bit p, input bit fmid);
    int          idx;
    bit          exp_hit;
    logic [63:0] exp_data;
    int          acc0;
    int          cyc;
    bit          got;
    idx      = int'(a[6:3]);
    exp_hit  = !w && (a[2:0] == 3'b000) && model_valid[idx] && (model_addr[idx] == a);
    exp_data = w ? 64'd0 : mem_val(a);
    acc0     = mem_accesses;
    cpu_request = '{addr: a, data: d, isWrite: w, isPrivileged: p, isValid: 1'b1};
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clock);
      cyc++;
      flush = fmid && (cyc == 1);
      if (cpu_result.isValid) got = 1'b1;
    end
    cpu_request.isValid = 1'b0;
    check("result_seen", {63'd0, got}, 64'd1);
    check("result_data", cpu_result.data, exp_data);
    check("mem_traffic", 64'(mem_accesses - acc0), exp_hit ? 64'd0 : 64'd1);
    if (exp_hit) begin
      check("hit_latency", 64'(cyc), 64'd1);
    end else begin
      check("mem_addr", last_addr, a);
      check("mem_iswrite", {63'd0, last_write}, {63'd0, w});
      check("mem_priv", {63'd0, last_priv}, {63'd0, p});
      check("mem_wdata", last_data, w ? d : 64'd0);
    end
    @(negedge clock);
    flush = 1'b0;
    check("result_pulse", {63'd0, cpu_result.isValid}, 64'd0);
    if (!exp_hit && (a[2:0] == 3'b000)) begin
      model_valid[idx] = 1'b1;
      model_addr[idx]  = a;
    end
    if (fmid) model_invalidate();
    $display("txn %s addr=%h wdata=%h priv=%0d hit=%0d midflush=%0d cycles=%0d rdata=%h",
             w ? "WR" : "RD", a, d, p, exp_hit, fmid, cyc, cpu_result.data);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_quiet", {63'd0, cpu_result.isValid | mem_request.isValid}, 64'd0);
    model_invalidate();
    $display("txn FLUSH");
  endtask

  initial begin
    logic [63:0] a;
    int          r;
    reset       = 1'b1;
    flush       = 1'b0;
    cpu_request = '0;
    mem_result  = '0;
    model_invalidate();
    mem_words[64'h50] = 64'habcd;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_cpu_valid", {63'd0, cpu_result.isValid}, 64'd0);
    check("reset_cpu_data", cpu_result.data, 64'd0);
    check("reset_mem_valid", {63'd0, mem_request.isValid}, 64'd0);
    check("reset_mem_addr", mem_request.addr, 64'd0);

    do_req(64'h50, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h50, 64'd0, 1'b0, 1'b1, 1'b0);
    do_req(64'h60, 64'h1, 1'b1, 1'b0, 1'b0);
    do_req(64'h60, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h60, 64'h2, 1'b1, 1'b0, 1'b0);
    do_req(64'hE0, 64'h3, 1'b1, 1'b1, 1'b0);
    do_req(64'h60, 64'd0, 1'b0, 1'b0, 1'b0);
    do_flush();
    do_req(64'h50, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h70, 64'd0, 1'b0, 1'b0, 1'b1);
    do_req(64'h70, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h92, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h90, 64'd0, 1'b0, 1'b0, 1'b0);
    do_req(64'h50, 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a write whose memory answer never comes.
    mem_enable  = 1'b0;
    cpu_request = '{addr: 64'h50, data: 64'h77, isWrite: 1'b1, isPrivileged: 1'b0, isValid: 1'b1};
    repeat (2) @(negedge clock);
    check("wr_pending", {63'd0, mem_request.isValid & mem_request.isWrite}, 64'd1);
    reset       = 1'b1;
    cpu_request = '0;
    @(negedge clock);
    reset = 1'b0;
    check("rst_cpu_valid", {63'd0, cpu_result.isValid}, 64'd0);
    check("rst_mem_valid", {63'd0, mem_request.isValid}, 64'd0);
    check("rst_mem_addr", mem_request.addr, 64'd0);
    check("rst_mem_data", mem_request.data, 64'd0);
    @(negedge clock);
    #1 mem_result = '{data: 64'hdead, isValid: 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stray_ignored", {63'd0, cpu_result.isValid | mem_request.isValid}, 64'd0);
    end
    mem_enable = 1'b1;
    model_invalidate();
    $display("txn RESET mid-write");
    do_req(64'h50, 64'd0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = 64'(($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 3));
      if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
      r = $urandom_range(0, 19);
      if (r < 11)
        do_req(a, 64'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 18)
        do_req(a, {$urandom, $urandom}, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      else if (r == 18)
        do_flush();
      else
        do_req(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
